uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8N1 frames (8 data bits, LSB first, one stop bit) from the asynchronous serial input `rxd`. Each good byte is presented on a valid/ready output port with a one-entry holding register. It is the receive-side counterpart of the UART transmitter and shares its clocking parameters, so a TX/RX pair configured identically interoperates. Errors are reported as single-cycle pulses.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115_200, line bit rate
- `CLKS_PER_BIT`, CLK_HZ/BAUD_RATE (integer division, 434 at defaults), clock cycles per bit; must be >= 4; may be overridden directly
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-low reset (0 = reset)
- `rxd`  input  1  asynchronous serial line, idle high
- `rx_ready`  input  1  consumer accepts byte when high with `rx_valid`
- `rx_valid`  output  1  holding register contains an unconsumed byte
- `rx_data`  output  8  received byte, stable while `rx_valid` is high
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `overrun`  output  1  one-cycle pulse: frame completed while holding register full and not being drained
- `parity_err`  output  1  one-cycle pulse: parity mismatch (tied 0 when parity is compiled out)

## Operation
- `rxd` passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_IDLE.
- IDLE: on `rxs`==0, clear the baud counter and go to START.
- START: after CLKS_PER_BIT/2 cycles, sample `rxs`. If 0, reset the counter and go to DATA. If 1, treat as a glitch and return to IDLE with no pulse.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift into the shift register LSB first. After the 8th sample go to PARITY or STOP.
- PARITY: sample one bit and compare it against the even parity of the data. A mismatch flags the frame; go to STOP.
- STOP, sample 1 (good frame): the byte is offered to the holding register (rules below). Go to IDLE.
- STOP, sample 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
- Parity-flagged frame with a good stop bit: pulse `parity_err` and discard the byte.
- WAIT_IDLE: stay until `rxs`==1 (break tolerance), then go to IDLE.
- Holding register rules:
  - Empty, or `rx_ready` high this cycle: load the byte and set `rx_valid`.
  - Full and `rx_ready` low: keep the old byte and pulse `overrun`.
  - `rx_valid && rx_ready` with no new byte: clear `rx_valid`.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps. The bit counter is 3 bits.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0, `parity_err`=0, FSM=IDLE, counters=0.
- Reset mid-frame aborts the frame with no pulses; the first frame after reset starts from IDLE.
- Synchronizer latency is 2 cycles.
- Start falling edge at `rxd` to stop-bit sample: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (10· with parity), ±1.
- `rx_valid` rises on the cycle after the stop-bit sample edge. Error pulses also fire in that cycle, for exactly one cycle.
- The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with a 1-bit stop are received without loss.
- `rx_ready` is a don't-care while `rx_valid`=0; there is no combinational path from `rx_ready` to `rx_valid`.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1. The PARITY state is present and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1. No PARITY state or parity logic is built, and `parity_err` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - the `UART_DATA_W`=8 constant;
  - a function computing CLKS_PER_BIT from CLK_HZ/BAUD_RATE, shared with the transmitter.
- One sub-module, `uart_sync2` (2-flop synchronizer with reset value parameter), reusable for other async inputs.

## Test plan
- Bench uses CLKS_PER_BIT=16.
- Byte 8'hA5, good stop bit, `rx_ready`=1 -> `rx_valid` pulses for 1 cycle with `rx_data`=8'hA5; no error pulses.
- Bytes 8'h00 then 8'hFF back to back, `rx_ready`=0 throughout -> `rx_valid`=1 with `rx_data`=8'h00; one `overrun` pulse after the second frame; `rx_data` stays 8'h00.
- Byte 8'h3C with the stop bit driven 0, then the line held low for 30 bit times -> one `frame_err`, `rx_valid` stays 0; FSM stays in WAIT_IDLE until the line rises, then a following 8'h55 is received correctly.
- 4-cycle low glitch on idle `rxd` -> no `rx_valid` and no error pulses; FSM back in IDLE.
- Reset asserted during the 4th data bit of 8'hC3, then a full frame 8'h81 -> no output from the aborted frame; 8'h81 is delivered.
- With `UART_RX_PARITY_EN`: 8'h07 with parity bit 0 (wrong) -> one `parity_err` pulse, no `rx_valid`; 8'h07 with parity bit 1 -> `rx_data`=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, data width and the
// baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_e;

  // Integer division; a TX/RX pair built from the same CLK_HZ/BAUD_RATE
  // therefore lands on the same divisor.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud_rate);
    return clk_hz / baud_rate;
  endfunction

  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// take RST_VAL under synchronous active-low reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) into a
// one-entry valid/ready holding register, with single-cycle error pulses.
//
// Output handshake: rx_valid stays high until a cycle with rx_valid && rx_ready;
// rx_data is stable while rx_valid is high; rx_ready never reaches rx_valid
// combinationally and is ignored while rx_valid is low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD_RATE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  input  logic                   rx_ready,
  output logic                   rx_valid,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err,
  output logic [2:0]             o_dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                   w_rxs;
  logic                   w_tick;
  logic                   w_half;
  logic                   w_stop_sample;
  logic                   w_par_flag;
  logic                   w_good_frame;
  logic                   w_frame_bad;
  logic                   w_par_bad;

  uart_rx_state_e         r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit_cnt;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_valid;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_frame_err;
  logic                   r_overrun;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync_rxd (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (rxd),
    .o_q     (w_rxs)
  );

  assign w_tick        = (r_cnt == CNT_LAST);
  assign w_half        = (r_cnt == CNT_HALF);
  assign w_stop_sample = (r_state == ST_STOP) && w_tick;
  assign w_frame_bad   = w_stop_sample && !w_rxs;
  assign w_good_frame  = w_stop_sample && w_rxs && !w_par_flag;
  assign w_par_bad     = w_stop_sample && w_rxs && w_par_flag;

`ifdef UART_RX_PARITY_EN
  logic r_par_flag;
  logic r_parity_err;

  assign w_par_flag = r_par_flag;
  assign parity_err = r_parity_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_flag   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_bad;
      if (r_state == ST_START) begin
        r_par_flag <= 1'b0;
      end else if ((r_state == ST_PARITY) && w_tick) begin
        r_par_flag <= (w_rxs != even_parity(r_shift));
      end
    end
  end
`else
  assign w_par_flag = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Bit-level sequencing; every state leaves its counter at 0 for the next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_half) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rxs ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[UART_DATA_W-1:1]};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= w_rxs ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          if (w_rxs) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Holding register: a new byte wins over a simultaneous drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= w_good_frame && r_valid && !rx_ready;
      if (w_good_frame) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid    = r_valid;
  assign rx_data     = r_data;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at CLKS_PER_BIT=16; honours
// UART_RX_PARITY_EN when it is defined for both bench and design.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic [2:0] dbg_state;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rx_ready    (rx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .parity_err  (parity_err),
    .o_dbg_state (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_valid_cyc = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_perr = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  int v0, f0, o0, p0;

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) n_valid_cyc <= n_valid_cyc + 1;
      if (rx_valid && !prev_valid) rise_cyc <= cyc;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_ferr <= n_ferr + 1;
      if (overrun) n_ovr <= n_ovr + 1;
      if (parity_err) n_perr <= n_perr + 1;
    end
    prev_valid <= rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, 32'(g), 32'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`else
    if (bad_par) $display("note: parity not built, bad_par ignored");
`endif
    drive_bit(stop_bit);
  endtask

  task automatic snap();
    v0 = n_valid_cyc;
    f0 = n_ferr;
    o0 = n_ovr;
    p0 = n_perr;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] first;
    int start_cyc;
    int lat;
    int exp_lat;
    int k;

    rst = 1'b0;
    rxd = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(5);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    wait_cyc(2 * CPB);

    // Single byte, consumer always ready
    snap();
    start_cyc = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_cyc(CPB);
    lat = rise_cyc - start_cyc;
    exp_lat = 2 + CPB / 2 + FRAME_BITS * CPB;
    chk("a5_latency_ok", 32'((lat >= exp_lat - 1) && (lat <= exp_lat + 2)), 32'd1);
    chk("a5_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
    chk("a5_no_errs", 32'((n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)), 32'd0);
    chk("a5_data_held", 32'(rx_data), 32'hA5);
    sb_check("a5");

    // Back-to-back bytes with no consumer: second frame overruns
    rx_ready = 1'b0;
    snap();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_cyc(CPB);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h00);
    chk("ovr_pulses", 32'(n_ovr - o0), 32'd1);
    chk("ovr_no_ferr", 32'(n_ferr - f0), 32'd0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    wait_cyc(4);
    chk("ovr_drained", 32'(rx_valid), 32'd0);
    sb_check("ovr");

    // Bad stop bit followed by a long break
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    wait_cyc(15 * CPB);
    chk("brk_state_mid", 32'(dbg_state), 32'(ST_WAIT_IDLE));
    wait_cyc(15 * CPB);
    chk("brk_state_end", 32'(dbg_state), 32'(ST_WAIT_IDLE));
    chk("brk_ferr", 32'(n_ferr - f0), 32'd1);
    chk("brk_no_valid", 32'(n_valid_cyc - v0), 32'd0);
    rxd = 1'b1;
    wait_cyc(5);
    chk("brk_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    wait_cyc(CPB);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_cyc(CPB);
    chk("brk_ferr_once", 32'(n_ferr - f0), 32'd1);
    sb_check("brk_55");

    // Short low glitch on an idle line
    snap();
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    wait_cyc(2 * CPB);
    chk("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("glitch_no_valid", 32'(n_valid_cyc - v0), 32'd0);
    chk("glitch_no_errs", 32'((n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)), 32'd0);

    // Reset in the middle of the 4th data bit
    snap();
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rxd = d[3];
    wait_cyc(CPB / 2);
    rst = 1'b0;
    rxd = 1'b1;
    wait_cyc(3);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    rst = 1'b1;
    wait_cyc(2 * CPB);
    chk("midrst_quiet", 32'((n_valid_cyc - v0) + (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(CPB);
    sb_check("midrst_81");

    // Random back-to-back burst, consumer ready
    snap();
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0);
    end
    wait_cyc(CPB);
    chk("burst_no_errs", 32'((n_ferr - f0) + (n_ovr - o0) + (n_perr - p0)), 32'd0);
    sb_check("burst");

    // Random slow consumer: only the first byte survives
    snap();
    k = int'($urandom_range(2, 4));
    rx_ready = 1'b0;
    first = 8'h00;
    for (int j = 0; j < k; j++) begin
      d = 8'($urandom_range(0, 255));
      if (j == 0) first = d;
      send_frame(d, 1'b1, 1'b0);
    end
    wait_cyc(CPB);
    chk("slow_valid", 32'(rx_valid), 32'd1);
    chk("slow_data", 32'(rx_data), 32'(first));
    chk("slow_ovr", 32'(n_ovr - o0), 32'(k - 1));
    rx_ready = 1'b1;
    exp_q.push_back(first);
    wait_cyc(4);
    sb_check("slow");

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 has three ones, so the correct parity bit is 1
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(CPB);
    chk("par_bad_pulse", 32'(n_perr - p0), 32'd1);
    chk("par_bad_no_valid", 32'(n_valid_cyc - v0), 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cyc(CPB);
    chk("par_good_no_pulse", 32'(n_perr - p0), 32'd1);
    sb_check("par_good");
`else
    chk("par_tied_low", 32'(n_perr), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
